// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs N narrow input beats into one wide output word.
// Lane 0 is the least-significant slice, and a tlast beat always closes the current word.
module axis_upsizer #(
   parameter int INPUT_DATA_WIDTH  = 8,
   parameter int INPUT_KEEP_WIDTH  = 1,
   parameter int OUTPUT_DATA_WIDTH = 64,
   parameter int OUTPUT_KEEP_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [INPUT_DATA_WIDTH-1:0]  input_axis_tdata,
   input  logic [INPUT_KEEP_WIDTH-1:0]  input_axis_tkeep,
   input  logic                         input_axis_tvalid,
   output logic                         input_axis_tready,
   input  logic                         input_axis_tlast,
   input  logic                         input_axis_tuser,
   output logic [OUTPUT_DATA_WIDTH-1:0] output_axis_tdata,
   output logic [OUTPUT_KEEP_WIDTH-1:0] output_axis_tkeep,
   output logic                         output_axis_tvalid,
   input  logic                         output_axis_tready,
   output logic                         output_axis_tlast,
   output logic                         output_axis_tuser
);

   localparam int N  = OUTPUT_DATA_WIDTH / INPUT_DATA_WIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LANE_LAST = CW'(N - 1);

   logic [OUTPUT_DATA_WIDTH-1:0] bufData_q, bufData_d;
   logic [OUTPUT_KEEP_WIDTH-1:0] bufKeep_q, bufKeep_d;
   logic                         bufUser_q, bufUser_d;
   logic [CW-1:0]                lane_q, lane_d;

   logic [OUTPUT_DATA_WIDTH-1:0] outData_q, outData_d;
   logic [OUTPUT_KEEP_WIDTH-1:0] outKeep_q, outKeep_d;
   logic                         outValid_q, outValid_d;
   logic                         outLast_q, outLast_d;
   logic                         outUser_q, outUser_d;

   logic [OUTPUT_DATA_WIDTH-1:0] mergedData;
   logic [OUTPUT_KEEP_WIDTH-1:0] mergedKeep;
   logic                         inReady;
   logic                         accept;
   logic                         complete;

   assign inReady  = !outValid_q || output_axis_tready;
   assign accept   = input_axis_tvalid && inReady;
   assign complete = accept && (input_axis_tlast || (lane_q == LANE_LAST));

   // The buffer is zero above the current lane, so lanes past a tlast beat come out as zero.
   always_comb begin
      mergedData = bufData_q;
      mergedKeep = bufKeep_q;
      for (int k = 0; k < N; k++) begin
         if (lane_q == CW'(k)) begin
            mergedData[k*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] = input_axis_tdata;
            mergedKeep[k*INPUT_KEEP_WIDTH +: INPUT_KEEP_WIDTH] = input_axis_tkeep;
         end
      end
   end

   // A completing beat reloads the output stage on the same edge it drains, so no bubble.
   always_comb begin
      bufData_d  = bufData_q;
      bufKeep_d  = bufKeep_q;
      bufUser_d  = bufUser_q;
      lane_d     = lane_q;
      outData_d  = outData_q;
      outKeep_d  = outKeep_q;
      outValid_d = outValid_q;
      outLast_d  = outLast_q;
      outUser_d  = outUser_q;

      if (outValid_q && output_axis_tready) begin
         outValid_d = 1'b0;
      end

      if (complete) begin
         outData_d  = mergedData;
         outKeep_d  = mergedKeep;
         outLast_d  = input_axis_tlast;
         outUser_d  = bufUser_q | input_axis_tuser;
         outValid_d = 1'b1;
         bufData_d  = '0;
         bufKeep_d  = '0;
         bufUser_d  = 1'b0;
         lane_d     = '0;
      end else if (accept) begin
         bufData_d  = mergedData;
         bufKeep_d  = mergedKeep;
         bufUser_d  = bufUser_q | input_axis_tuser;
         lane_d     = lane_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bufData_q  <= '0;
         bufKeep_q  <= '0;
         bufUser_q  <= 1'b0;
         lane_q     <= '0;
         outData_q  <= '0;
         outKeep_q  <= '0;
         outValid_q <= 1'b0;
         outLast_q  <= 1'b0;
         outUser_q  <= 1'b0;
      end else begin
         bufData_q  <= bufData_d;
         bufKeep_q  <= bufKeep_d;
         bufUser_q  <= bufUser_d;
         lane_q     <= lane_d;
         outData_q  <= outData_d;
         outKeep_q  <= outKeep_d;
         outValid_q <= outValid_d;
         outLast_q  <= outLast_d;
         outUser_q  <= outUser_d;
      end
   end

   assign input_axis_tready  = inReady;
   assign output_axis_tdata  = outData_q;
   assign output_axis_tkeep  = outKeep_q;
   assign output_axis_tvalid = outValid_q;
   assign output_axis_tlast  = outLast_q;
   assign output_axis_tuser  = outUser_q;

endmodule

// File: tb/tb_axis_upsizer.sv
// Self-checking bench for axis_upsizer: directed scenarios plus randomized packets
// scored against a packet-level reference model that packs bytes arithmetically.
module tb_axis_upsizer;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
   } word_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  input_axis_tdata;
   logic [0:0]  input_axis_tkeep;
   logic        input_axis_tvalid;
   logic        input_axis_tready;
   logic        input_axis_tlast;
   logic        input_axis_tuser;
   logic [63:0] output_axis_tdata;
   logic [7:0]  output_axis_tkeep;
   logic        output_axis_tvalid;
   logic        output_axis_tready;
   logic        output_axis_tlast;
   logic        output_axis_tuser;

   int total = 0;
   int bad   = 0;

   word_t       expQ[$];
   word_t       obsLog[$];
   logic [63:0] accData;
   logic [7:0]  accKeep;
   logic        accUser;
   int          accCnt;
   logic        stallPrev;
   word_t       held;
   word_t       cur;
   word_t       ew;

   axis_upsizer #(
      .INPUT_DATA_WIDTH(8),
      .INPUT_KEEP_WIDTH(1),
      .OUTPUT_DATA_WIDTH(64),
      .OUTPUT_KEEP_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .input_axis_tdata(input_axis_tdata),
      .input_axis_tkeep(input_axis_tkeep),
      .input_axis_tvalid(input_axis_tvalid),
      .input_axis_tready(input_axis_tready),
      .input_axis_tlast(input_axis_tlast),
      .input_axis_tuser(input_axis_tuser),
      .output_axis_tdata(output_axis_tdata),
      .output_axis_tkeep(output_axis_tkeep),
      .output_axis_tvalid(output_axis_tvalid),
      .output_axis_tready(output_axis_tready),
      .output_axis_tlast(output_axis_tlast),
      .output_axis_tuser(output_axis_tuser)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Negedge monitor: scoreboard, hold-stability check, and reference model update.
   initial begin
      accData = '0; accKeep = '0; accUser = 1'b0; accCnt = 0; stallPrev = 1'b0;
      forever begin
         @(negedge clk);
         cur = '{d: output_axis_tdata, k: output_axis_tkeep, l: output_axis_tlast, u: output_axis_tuser};
         if (rst) begin
            expQ.delete();
            accData = '0; accKeep = '0; accUser = 1'b0; accCnt = 0; stallPrev = 1'b0;
         end else begin
            if (stallPrev) begin
               total++;
               if (cur !== held || output_axis_tvalid !== 1'b1) begin
                  bad++;
                  $display("[TB] FAIL hold_stable: got %h valid %b, required %h valid 1", cur, output_axis_tvalid, held);
               end
            end
            if (output_axis_tvalid && output_axis_tready) begin
               obsLog.push_back(cur);
               total++;
               if (expQ.size() == 0) begin
                  bad++;
                  $display("[TB] FAIL scoreboard_extra: got word %h, none expected", cur);
               end else begin
                  ew = expQ.pop_front();
                  if (cur !== ew) begin
                     bad++;
                     $display("[TB] FAIL scoreboard_word: got %h, required %h", cur, ew);
                  end
               end
            end
            stallPrev = output_axis_tvalid && !output_axis_tready;
            held = cur;
            if (input_axis_tvalid && input_axis_tready) begin
               accData = accData | (64'(input_axis_tdata) << (8 * accCnt));
               accKeep = accKeep | (8'(input_axis_tkeep) << accCnt);
               accUser = accUser | input_axis_tuser;
               accCnt++;
               if (accCnt == 8 || input_axis_tlast) begin
                  expQ.push_back('{d: accData, k: accKeep, l: input_axis_tlast, u: accUser});
                  accData = '0; accKeep = '0; accUser = 1'b0; accCnt = 0;
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send_beat(input logic [7:0] d, input logic k, input logic l, input logic u, output int waits);
      logic rdy;
      int n = 0;
      input_axis_tdata  = d;
      input_axis_tkeep  = k;
      input_axis_tlast  = l;
      input_axis_tuser  = u;
      input_axis_tvalid = 1'b1;
      forever begin
         @(negedge clk);
         rdy = input_axis_tready;
         @(posedge clk);
         #1;
         if (rdy) break;
         n++;
         if (n > 200) begin
            total++; bad++;
            $display("[TB] FAIL send_timeout: got no accept after %0d cycles, required accept", n);
            break;
         end
      end
      input_axis_tvalid = 1'b0;
      input_axis_tlast  = 1'b0;
      input_axis_tuser  = 1'b0;
      waits = n;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      #2;
      total += 6;
      if (output_axis_tdata !== 64'h0) begin bad++; $display("[TB] FAIL reset_tdata: got %h required 0", output_axis_tdata); end
      if (output_axis_tkeep !== 8'h0) begin bad++; $display("[TB] FAIL reset_tkeep: got %h required 0", output_axis_tkeep); end
      if (output_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid: got %b required 0", output_axis_tvalid); end
      if (output_axis_tlast !== 1'b0) begin bad++; $display("[TB] FAIL reset_tlast: got %b required 0", output_axis_tlast); end
      if (output_axis_tuser !== 1'b0) begin bad++; $display("[TB] FAIL reset_tuser: got %b required 0", output_axis_tuser); end
      if (input_axis_tready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_tready: got %b required 1", input_axis_tready); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_example_word();
      logic [7:0] bytesIn [5];
      int w;
      bytesIn = '{8'hCD, 8'hAB, 8'hCD, 8'hAB, 8'hCD};
      output_axis_tready = 1'b1;
      obsLog.delete();
      for (int i = 0; i < 5; i++) begin
         send_beat(bytesIn[i], 1'b1, i == 4, 1'b0, w);
         if (i == 3) begin
            total++;
            if (output_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL ex_early_valid: got %b required 0", output_axis_tvalid); end
         end
      end
      total += 4;
      if (output_axis_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL ex_latency: got valid %b required 1", output_axis_tvalid); end
      if (output_axis_tdata !== 64'h000000CDABCDABCD) begin bad++; $display("[TB] FAIL ex_tdata: got %h required 000000cdabcdabcd", output_axis_tdata); end
      if (output_axis_tkeep !== 8'h1F) begin bad++; $display("[TB] FAIL ex_tkeep: got %h required 1f", output_axis_tkeep); end
      if (output_axis_tlast !== 1'b1) begin bad++; $display("[TB] FAIL ex_tlast: got %b required 1", output_axis_tlast); end
      idle_cycles(1);
      total++;
      if (output_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL ex_valid_clear: got %b required 0", output_axis_tvalid); end
      idle_cycles(2);
   endtask

   task automatic test_back_to_back();
      int w;
      int stalls = 0;
      obsLog.delete();
      output_axis_tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send_beat(8'(i), 1'b1, i == 15, 1'b0, w);
         stalls += w;
      end
      idle_cycles(3);
      total += 2;
      if (stalls != 0) begin bad++; $display("[TB] FAIL b2b_stalls: got %0d stall cycles required 0", stalls); end
      if (obsLog.size() != 2) begin
         bad++; $display("[TB] FAIL b2b_count: got %0d words required 2", obsLog.size());
      end else begin
         total++;
         if (obsLog[0] !== '{d: 64'h0706050403020100, k: 8'hFF, l: 1'b0, u: 1'b0}) begin
            bad++; $display("[TB] FAIL b2b_word0: got %h required 0706050403020100/ff/0/0", obsLog[0]);
         end
         total++;
         if (obsLog[1] !== '{d: 64'h0F0E0D0C0B0A0908, k: 8'hFF, l: 1'b1, u: 1'b0}) begin
            bad++; $display("[TB] FAIL b2b_word1: got %h required 0f0e0d0c0b0a0908/ff/1/0", obsLog[1]);
         end
      end
   endtask

   task automatic test_single_beat();
      int w;
      obsLog.delete();
      send_beat(8'hEE, 1'b1, 1'b1, 1'b1, w);
      idle_cycles(2);
      total++;
      if (obsLog.size() != 1) begin
         bad++; $display("[TB] FAIL single_count: got %0d words required 1", obsLog.size());
      end else begin
         total++;
         if (obsLog[0] !== '{d: 64'h00000000000000EE, k: 8'h01, l: 1'b1, u: 1'b1}) begin
            bad++; $display("[TB] FAIL single_word: got %h required ee/01/1/1", obsLog[0]);
         end
      end
   endtask

   task automatic test_backpressure();
      int w;
      output_axis_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send_beat(8'(8'h11 * (i + 1)), 1'b1, i == 7, 1'b0, w);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total += 3;
         if (output_axis_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid: got %b required 1", output_axis_tvalid); end
         if (output_axis_tdata !== 64'h8877665544332211) begin bad++; $display("[TB] FAIL bp_data: got %h required 8877665544332211", output_axis_tdata); end
         if (input_axis_tready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_tready: got %b required 0", input_axis_tready); end
         @(posedge clk);
         #1;
      end
      output_axis_tready = 1'b1;
      #1;
      total++;
      if (input_axis_tready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %b required 1", input_axis_tready); end
      @(posedge clk);
      #1;
      total++;
      if (output_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained: got %b required 0", output_axis_tvalid); end
      idle_cycles(1);
   endtask

   task automatic test_reset_mid_packet();
      int w;
      output_axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) send_beat(8'h55, 1'b1, 1'b0, 1'b1, w);
      rst = 1'b1;
      #1;
      total += 4;
      if (output_axis_tdata !== 64'h0) begin bad++; $display("[TB] FAIL rmid_tdata: got %h required 0", output_axis_tdata); end
      if (output_axis_tkeep !== 8'h0) begin bad++; $display("[TB] FAIL rmid_tkeep: got %h required 0", output_axis_tkeep); end
      if (output_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_tvalid: got %b required 0", output_axis_tvalid); end
      if (output_axis_tuser !== 1'b0) begin bad++; $display("[TB] FAIL rmid_tuser: got %b required 0", output_axis_tuser); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      obsLog.delete();
      for (int i = 0; i < 8; i++) send_beat(8'(8'hA0 + i), 1'b1, i == 7, 1'b0, w);
      idle_cycles(2);
      total++;
      if (obsLog.size() != 1) begin
         bad++; $display("[TB] FAIL rmid_count: got %0d words required 1", obsLog.size());
      end else begin
         total++;
         if (obsLog[0] !== '{d: 64'hA7A6A5A4A3A2A1A0, k: 8'hFF, l: 1'b1, u: 1'b0}) begin
            bad++; $display("[TB] FAIL rmid_word: got %h required a7a6a5a4a3a2a1a0/ff/1/0", obsLog[0]);
         end
      end
   endtask

   task automatic test_null_keep();
      int w;
      obsLog.delete();
      send_beat(8'h11, 1'b1, 1'b0, 1'b0, w);
      send_beat(8'h22, 1'b0, 1'b0, 1'b0, w);
      send_beat(8'h33, 1'b1, 1'b1, 1'b0, w);
      idle_cycles(2);
      total++;
      if (obsLog.size() != 1) begin
         bad++; $display("[TB] FAIL nullkeep_count: got %0d words required 1", obsLog.size());
      end else begin
         total++;
         if (obsLog[0] !== '{d: 64'h0000000000332211, k: 8'h05, l: 1'b1, u: 1'b0}) begin
            bad++; $display("[TB] FAIL nullkeep_word: got %h required 332211/05/1/0", obsLog[0]);
         end
      end
   endtask

   task automatic test_random();
      bit stopToggle = 1'b0;
      int w;
      fork
         begin
            for (int p = 0; p < 60; p++) begin
               int len = $urandom_range(1, 20);
               for (int i = 0; i < len; i++) begin
                  if ($urandom_range(0, 3) == 0) begin
                     input_axis_tdata = 8'($urandom);
                     idle_cycles($urandom_range(1, 2));
                  end
                  send_beat(8'($urandom), ($urandom_range(0, 4) != 0), i == len - 1,
                            ($urandom_range(0, 9) == 0), w);
               end
            end
            stopToggle = 1'b1;
         end
         begin
            while (!stopToggle) begin
               @(posedge clk);
               #1;
               output_axis_tready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      output_axis_tready = 1'b1;
      idle_cycles(20);
      total++;
      if (expQ.size() != 0) begin bad++; $display("[TB] FAIL rand_drain: got %0d words pending required 0", expQ.size()); end
   endtask

   initial begin
      rst = 1'b0;
      input_axis_tdata   = '0;
      input_axis_tkeep   = '0;
      input_axis_tvalid  = 1'b0;
      input_axis_tlast   = 1'b0;
      input_axis_tuser   = 1'b0;
      output_axis_tready = 1'b1;
      #1 rst = 1'b1;
      test_reset();
      test_example_word();
      test_back_to_back();
      test_single_beat();
      test_backpressure();
      test_reset_mid_packet();
      test_null_keep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
